regfile_responder: RTL and testbench
====================================

// Module: regfile_responder
// PURPOSE
//  Register-file responder on the far side of the decode-stage register interface.
//  Decode drives two read addresses and one write (enable/addr/data); this block answers with read data the same cycle.
//  Holds 32 x 32-bit integer registers; x0 is hardwired to zero.
//  Adds a post-reset sequential clear engine and a valid/ready dump stream for bench inspection.
// PARAMETERS
//  XLEN    32  data width
//  NREG    32  number of architectural registers
//  ADDR_W  32  width of address ports; only [4:0] index the array
//  IDX_W   5   log2(NREG)
// PORTS
//  clk         in   1       clock, rising edge
//  reset_n     in   1       asynchronous, active-low reset
//  rd_addr1    in   ADDR_W  read address, port 1 (from decode)
//  rd_addr2    in   ADDR_W  read address, port 2 (from decode)
//  rd_data1    out  XLEN    read data, port 1, combinational
//  rd_data2    out  XLEN    read data, port 2, combinational
//  wr_en       in   1       write enable (writeback op_write)
//  wr_addr     in   ADDR_W  write address
//  wr_data     in   XLEN    write data
//  init_busy   out  1       clear engine running
//  addr_err    out  1       registered one-cycle pulse: previous cycle had an out-of-range access
//  dump_req    in   1       start dump (level, sampled in IDLE)
//  dump_valid  out  1       dump beat valid
//  dump_ready  in   1       bench accepts beat
//  dump_idx    out  IDX_W   register index of current beat
//  dump_data   out  XLEN    register value of current beat
//  dump_done   out  1       one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset (async assert): FSM=INIT, clear ptr=1, init_busy=1.
//   All other registered outputs are 0: addr_err, dump_valid, dump_idx, dump_done.
//   While reset_n=0, rd_data1/2 = 0. Array contents are not reset directly; INIT clears them.
//  FSM INIT: writes 0 to reg[ptr] each cycle, ptr 1..31 (31 cycles).
//   At ptr=31, the next state is IDLE and init_busy drops.
//   In INIT: rd_data = 0, wr_en ignored, dump_req ignored.
//  FSM IDLE: normal service. If dump_req=1, go to DUMP with dump_idx=0 and dump_valid=1 next cycle.
//  FSM DUMP: dump_data = read of dump_idx, with the same bypass as read ports.
//   Beat accepted when dump_valid & dump_ready; then idx increments.
//   Idx 31 accepted -> dump_valid=0, dump_done=1 for one cycle, then IDLE.
//   Stalled beat (ready=0): idx and valid hold; dump_data tracks any write to that idx.
//   dump_req is ignored during DUMP.
//  Reads (IDLE/DUMP): rd_addr[ADDR_W-1:IDX_W] != 0 -> rd_data = 0 and flag error. addr==0 -> 0.
//   Otherwise reg[addr]. Write-first bypass: if wr_en & wr_addr==rd_addr & addr!=0 & in range, rd_data = wr_data.
//  Writes (IDLE/DUMP): on posedge, if wr_en & in range & addr!=0, reg[addr] <= wr_data.
//   Writes to x0 are dropped silently. Out-of-range writes are dropped and flag error.
//  addr_err: registered OR of the three port error flags (rd1, rd2, write) from the previous cycle. Held 0 in INIT.
//  Both read ports may address the same register; each gets the same value.
//  Reset mid-DUMP or mid-INIT: abort immediately; restart INIT.
//   dump_done is not asserted for an aborted dump.
// TESTING
//  T1 release reset, poll -> init_busy high exactly 31 cycles; then rd_addr1=5 -> rd_data1=0.
//  T2 wr_en=1,wr_addr=3,wr_data=0xDEADBEEF,rd_addr1=3 same cycle -> rd_data1=0xDEADBEEF (bypass); next cycle wr_en=0 -> still 0xDEADBEEF.
//  T3 wr_en=1,wr_addr=0,wr_data=0x1234 then rd_addr2=0 -> rd_data2=0, addr_err=0.
//  T4 rd_addr1=32 -> rd_data1=0 and addr_err=1 next cycle only; wr_addr=40 write -> array unchanged, addr_err=1.
//  T5 write reg[i]=i*0x11 for i=1..31, dump_req=1, dump_ready toggled 1/0 -> 32 beats idx 0..31, data 0,0x11..0x20F, no beat lost/duplicated, dump_done 1 pulse.
//  T6 assert reset_n=0 during beat 10 of dump -> dump_valid=0 at once, init_busy=1, 31-cycle INIT reruns, no dump_done.

Source files
------------

// File: rtl/regfile_responder_if.sv
// Decode-stage register interface: two read ports, one write port,
// clear-engine status, error pulse and the register dump stream.
// master = decode / bench side, slave = register-file responder.
interface regfile_responder_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 5
);
   logic [ADDR_W-1:0] rd_addr1;
   logic [ADDR_W-1:0] rd_addr2;
   logic [XLEN-1:0]   rd_data1;
   logic [XLEN-1:0]   rd_data2;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [XLEN-1:0]   wr_data;
   logic              init_busy;
   logic              addr_err;
   logic              dump_req;
   logic              dump_valid;
   logic              dump_ready;
   logic [IDX_W-1:0]  dump_idx;
   logic [XLEN-1:0]   dump_data;
   logic              dump_done;

   modport master (
      output rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, dump_req, dump_ready,
      input  rd_data1, rd_data2, init_busy, addr_err, dump_valid, dump_idx,
             dump_data, dump_done
   );

   modport slave (
      input  rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, dump_req, dump_ready,
      output rd_data1, rd_data2, init_busy, addr_err, dump_valid, dump_idx,
             dump_data, dump_done
   );
endinterface

// File: rtl/regfile_responder.sv
// Register-file responder: 32 x XLEN integer registers, x0 hardwired to zero.
// Combinational reads with write-first bypass, a post-reset clear engine that
// zeroes x1..x31 one per cycle, and a valid/ready stream dumping all registers.
module regfile_responder #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 5
) (
   input logic                clk,
   input logic                reset_n,
   regfile_responder_if.slave rf
);
   typedef enum logic [1:0] {
      ST_INIT = 2'd0,
      ST_IDLE = 2'd1,
      ST_DUMP = 2'd2
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREG - 1);
   localparam int NPORT = 3;   // rd port 1, rd port 2, dump read

   state_t           state_reg;
   logic [IDX_W-1:0] ptr_reg;
   logic             init_busy_reg;
   logic             addr_err_reg;
   logic             dump_valid_reg;
   logic [IDX_W-1:0] dump_idx_reg;
   logic             dump_done_reg;

   // Register storage; no reset, the clear engine zeroes it after every reset.
   logic [XLEN-1:0] mem [NREG];

   logic             service;
   logic             wr_oob;
   logic [IDX_W-1:0] wr_idx;
   logic             wr_live;
   logic             err_any;

   logic [ADDR_W-1:0] port_addr [NPORT];
   logic [XLEN-1:0]   port_data [NPORT];
   logic [NPORT-1:0]  port_oob;

   // Normal service (reads, writes, error reporting) only outside the clear phase.
   assign service = (state_reg != ST_INIT);

   // A write lands (and bypasses to readers) only when in range and not x0.
   assign wr_oob  = |rf.wr_addr[ADDR_W-1:IDX_W];
   assign wr_idx  = rf.wr_addr[IDX_W-1:0];
   assign wr_live = service & rf.wr_en & ~wr_oob & (wr_idx != '0);

   assign port_addr[0] = rf.rd_addr1;
   assign port_addr[1] = rf.rd_addr2;
   assign port_addr[2] = {{(ADDR_W-IDX_W){1'b0}}, dump_idx_reg};

   // Identical read path for both decode ports and the dump beat.
   generate
      for (genvar gi = 0; gi < NPORT; gi++) begin : g_rd
         logic [IDX_W-1:0] idx;
         assign idx          = port_addr[gi][IDX_W-1:0];
         assign port_oob[gi] = |port_addr[gi][ADDR_W-1:IDX_W];
         assign port_data[gi] =
            (!service || port_oob[gi] || idx == '0) ? '0 :
            (wr_live && wr_idx == idx)              ? rf.wr_data :
                                                      mem[idx];
      end
   endgenerate

   // Only the decode-facing ports and the write port can raise an error.
   assign err_any = port_oob[0] | port_oob[1] | (rf.wr_en & wr_oob);

   assign rf.rd_data1   = port_data[0];
   assign rf.rd_data2   = port_data[1];
   assign rf.dump_data  = dump_valid_reg ? port_data[2] : '0;
   assign rf.init_busy  = init_busy_reg;
   assign rf.addr_err   = addr_err_reg;
   assign rf.dump_valid = dump_valid_reg;
   assign rf.dump_idx   = dump_idx_reg;
   assign rf.dump_done  = dump_done_reg;

   // Array write port: clear engine during INIT, architectural writes otherwise.
   always_ff @(posedge clk) begin
      if (state_reg == ST_INIT) begin
         mem[ptr_reg] <= '0;
      end else if (wr_live) begin
         mem[wr_idx] <= rf.wr_data;
      end
   end

   // Control FSM: clear sweep, idle service, and the dump stream handshake.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg      <= ST_INIT;
         ptr_reg        <= IDX_W'(1);
         init_busy_reg  <= 1'b1;
         addr_err_reg   <= 1'b0;
         dump_valid_reg <= 1'b0;
         dump_idx_reg   <= '0;
         dump_done_reg  <= 1'b0;
      end else begin
         dump_done_reg <= 1'b0;
         addr_err_reg  <= service & err_any;
         case (state_reg)
            ST_INIT: begin
               ptr_reg <= ptr_reg + IDX_W'(1);
               if (ptr_reg == LAST_IDX) begin
                  state_reg     <= ST_IDLE;
                  init_busy_reg <= 1'b0;
               end
            end
            ST_IDLE: begin
               if (rf.dump_req) begin
                  state_reg      <= ST_DUMP;
                  dump_valid_reg <= 1'b1;
                  dump_idx_reg   <= '0;
               end
            end
            ST_DUMP: begin
               if (dump_valid_reg && rf.dump_ready) begin
                  if (dump_idx_reg == LAST_IDX) begin
                     state_reg      <= ST_IDLE;
                     dump_valid_reg <= 1'b0;
                     dump_done_reg  <= 1'b1;
                     dump_idx_reg   <= '0;
                  end else begin
                     dump_idx_reg <= dump_idx_reg + IDX_W'(1);
                  end
               end
            end
            default: begin
               state_reg <= ST_INIT;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_regfile_responder.sv
// Bench for regfile_responder: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a behavioural register-file model.
module tb_regfile_responder;
   localparam int XLEN   = 32;
   localparam int NREG   = 32;
   localparam int ADDR_W = 32;
   localparam int IDX_W  = 5;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   regfile_responder_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) rf ();

   regfile_responder #(.XLEN(XLEN), .NREG(NREG), .ADDR_W(ADDR_W), .IDX_W(IDX_W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .rf      (rf.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // Behavioural model state
   logic [31:0] m_mem [32];
   int          m_init_left = 31;
   bit          m_dumping   = 1'b0;
   int          m_didx      = 0;
   bit          m_done      = 1'b0;
   bit          m_err       = 1'b0;

   // Observed dump stream
   logic [4:0]  beat_idx  [$];
   logic [31:0] beat_data [$];
   int          done_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Register value a reader sees right now, given the write presented this cycle.
   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a >= 32 || a == 0) return 32'h0;
      if (rf.wr_en && rf.wr_addr == a) return rf.wr_data;
      return m_mem[a[4:0]];
   endfunction

   // Model advance on each rising edge
   initial begin
      foreach (m_mem[i]) m_mem[i] = 32'h0;
      forever begin
         @(posedge clk);
         if (!reset_n) begin
            m_init_left = 31;
            m_dumping   = 1'b0;
            m_didx      = 0;
            m_done      = 1'b0;
            m_err       = 1'b0;
            foreach (m_mem[i]) m_mem[i] = 32'h0;
         end else if (m_init_left > 0) begin
            m_init_left = m_init_left - 1;
            m_err       = 1'b0;
            m_done      = 1'b0;
         end else begin
            m_err  = (rf.rd_addr1 >= 32) || (rf.rd_addr2 >= 32) || (rf.wr_en && rf.wr_addr >= 32);
            m_done = 1'b0;
            if (m_dumping) begin
               if (rf.dump_ready) begin
                  if (m_didx == 31) begin
                     m_dumping = 1'b0;
                     m_done    = 1'b1;
                  end else begin
                     m_didx = m_didx + 1;
                  end
               end
            end else if (rf.dump_req) begin
               m_dumping = 1'b1;
               m_didx    = 0;
            end
            if (rf.wr_en && rf.wr_addr < 32 && rf.wr_addr != 0)
               m_mem[rf.wr_addr[4:0]] = rf.wr_data;
         end
      end
   end

   // Per-cycle compare and dump-stream monitor on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            chk("rst_init_busy",  32'(rf.init_busy),  32'h1);
            chk("rst_addr_err",   32'(rf.addr_err),   32'h0);
            chk("rst_dump_valid", 32'(rf.dump_valid), 32'h0);
            chk("rst_dump_done",  32'(rf.dump_done),  32'h0);
            chk("rst_dump_idx",   32'(rf.dump_idx),   32'h0);
            chk("rst_rd_data1",   rf.rd_data1,        32'h0);
            chk("rst_rd_data2",   rf.rd_data2,        32'h0);
         end else begin
            chk("init_busy",  32'(rf.init_busy),  32'(m_init_left > 0));
            chk("addr_err",   32'(rf.addr_err),   32'(m_err));
            chk("dump_valid", 32'(rf.dump_valid), 32'(m_dumping));
            chk("dump_done",  32'(rf.dump_done),  32'(m_done));
            chk("rd_data1", rf.rd_data1, (m_init_left > 0) ? 32'h0 : m_read(rf.rd_addr1));
            chk("rd_data2", rf.rd_data2, (m_init_left > 0) ? 32'h0 : m_read(rf.rd_addr2));
            if (m_dumping) begin
               chk("dump_idx",  32'(rf.dump_idx), 32'(m_didx));
               chk("dump_data", rf.dump_data,     m_read(32'(m_didx)));
            end
            if (rf.dump_valid && rf.dump_ready) begin
               beat_idx.push_back(rf.dump_idx);
               beat_data.push_back(rf.dump_data);
            end
            if (rf.dump_done) done_cnt++;
         end
      end
   end

   // Directed scenarios and random traffic
   initial begin
      int cnt;
      int c;
      int base;
      int done0;
      rf.rd_addr1   = '0;
      rf.rd_addr2   = '0;
      rf.wr_en      = 1'b0;
      rf.wr_addr    = '0;
      rf.wr_data    = '0;
      rf.dump_req   = 1'b0;
      rf.dump_ready = 1'b0;
      reset_n       = 1'b0;
      repeat (3) step();
      reset_n = 1'b1;

      // T1: clear engine runs 31 cycles, registers read back zero
      cnt = 0;
      while (rf.init_busy && cnt < 100) begin
         cnt++;
         step();
      end
      chk("t1_init_cycles", 32'(cnt), 32'd31);
      rf.rd_addr1 = 32'd5;
      #1;
      chk("t1_rd5_zero", rf.rd_data1, 32'h0);
      step();

      // T2: write-first bypass, then stored value
      rf.wr_en = 1'b1; rf.wr_addr = 32'd3; rf.wr_data = 32'hDEADBEEF; rf.rd_addr1 = 32'd3;
      #1;
      chk("t2_bypass", rf.rd_data1, 32'hDEADBEEF);
      step();
      rf.wr_en = 1'b0;
      #1;
      chk("t2_stored", rf.rd_data1, 32'hDEADBEEF);

      // T3: writes to x0 are dropped without error
      step();
      rf.wr_en = 1'b1; rf.wr_addr = 32'd0; rf.wr_data = 32'h1234; rf.rd_addr2 = 32'd0;
      #1;
      chk("t3_x0_bypass", rf.rd_data2, 32'h0);
      step();
      rf.wr_en = 1'b0;
      #1;
      chk("t3_x0_read", rf.rd_data2, 32'h0);
      chk("t3_no_err", 32'(rf.addr_err), 32'h0);

      // T4: out-of-range read and write
      rf.wr_en = 1'b1; rf.wr_addr = 32'd8; rf.wr_data = 32'h55;
      step();
      rf.wr_en = 1'b0; rf.rd_addr1 = 32'd32;
      #1;
      chk("t4_oob_read", rf.rd_data1, 32'h0);
      step();
      rf.rd_addr1 = 32'd8;
      #1;
      chk("t4_err_set", 32'(rf.addr_err), 32'h1);
      chk("t4_rd8", rf.rd_data1, 32'h55);
      step();
      chk("t4_err_clear", 32'(rf.addr_err), 32'h0);
      rf.wr_en = 1'b1; rf.wr_addr = 32'd40; rf.wr_data = 32'hBAD;
      step();
      rf.wr_en = 1'b0;
      #1;
      chk("t4_wr_err", 32'(rf.addr_err), 32'h1);
      chk("t4_rd8_unchanged", rf.rd_data1, 32'h55);

      // T5: fill registers, dump with ready toggling
      for (int i = 1; i < 32; i++) begin
         rf.wr_en = 1'b1; rf.wr_addr = 32'(i); rf.wr_data = 32'(i * 32'h11);
         step();
      end
      rf.wr_en = 1'b0; rf.rd_addr1 = '0; rf.rd_addr2 = '0;
      base  = beat_idx.size();
      done0 = done_cnt;
      rf.dump_req = 1'b1; rf.dump_ready = 1'b0;
      step();
      rf.dump_req = 1'b0;
      c = 0;
      while (done_cnt == done0 && c < 300) begin
         rf.dump_ready = (c % 2 == 0);
         c++;
         step();
      end
      rf.dump_ready = 1'b0;
      step();
      step();
      chk("t5_finished", 32'(c < 300), 32'h1);
      chk("t5_beat_count", 32'(beat_idx.size() - base), 32'd32);
      for (int k = 0; k < 32; k++) begin
         if (base + k < beat_idx.size()) begin
            chk("t5_beat_idx",  32'(beat_idx[base + k]), 32'(k));
            chk("t5_beat_data", beat_data[base + k],     32'(k * 32'h11));
         end
      end
      chk("t5_done_pulses", 32'(done_cnt - done0), 32'd1);

      // Random traffic against the model
      for (int r = 0; r < 400; r++) begin
         rf.rd_addr1   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
         rf.rd_addr2   = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
         rf.wr_en      = $urandom_range(0, 1) == 1;
         rf.wr_addr    = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 31));
         rf.wr_data    = $urandom;
         rf.dump_req   = $urandom_range(0, 15) == 0;
         rf.dump_ready = $urandom_range(0, 1) == 1;
         step();
      end
      rf.wr_en = 1'b0; rf.dump_req = 1'b0; rf.dump_ready = 1'b1;
      rf.rd_addr1 = '0; rf.rd_addr2 = '0;
      c = 0;
      while (rf.dump_valid && c < 100) begin
         c++;
         step();
      end
      chk("rand_drain", 32'(rf.dump_valid), 32'h0);

      // T6: reset in the middle of a dump
      rf.dump_req = 1'b1;
      step();
      rf.dump_req = 1'b0;
      c = 0;
      while (!(rf.dump_valid && rf.dump_idx == 5'd10) && c < 50) begin
         c++;
         step();
      end
      chk("t6_reached_beat10", 32'(rf.dump_valid && rf.dump_idx == 5'd10), 32'h1);
      done0   = done_cnt;
      reset_n = 1'b0;
      #1;
      chk("t6_valid_drop", 32'(rf.dump_valid), 32'h0);
      chk("t6_busy", 32'(rf.init_busy), 32'h1);
      step();
      step();
      reset_n = 1'b1;
      cnt = 0;
      while (rf.init_busy && cnt < 100) begin
         cnt++;
         step();
      end
      chk("t6_init_cycles", 32'(cnt), 32'd31);
      rf.rd_addr1 = 32'd3;
      #1;
      chk("t6_cleared", rf.rd_data1, 32'h0);
      step();
      step();
      chk("t6_no_done", 32'(done_cnt - done0), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
